// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: handshake-loaded, prescaled LED pattern sequencer driving an active-low 4-bit LED bank.
module led_pattern_ctrl #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_period,
  input  logic [7:0]       cfg_repeat,
  input  logic             abort,
  output logic [3:0]       pio_led,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] per_q;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [7:0]       rep_q, pass_q, pass_d;
  logic [2:0]       step_q, step_d, last_step;
  logic [3:0]       led_q;
  logic             busy_q, done_q, pre_end, wrap, fin;

  // Active-low step patterns; bounce walks back through the inner LEDs.
  function automatic logic [3:0] pat(input logic [1:0] m, input logic [2:0] s);
    case (m)
      2'd0:    pat = ~(4'b1000 >> s);
      2'd1:    pat = ~(4'b0001 << s);
      2'd2:    pat = (s == 3'd0) ? 4'b0000 : 4'b1111;
      default: pat = (s < 3'd4) ? ~(4'b1000 >> s) : ~(4'b1000 >> (3'd6 - s));
    endcase
  endfunction

  // per_q holds P-1 so the prescaler terminal count is a plain compare.
  always_comb begin
    last_step = (mode_q == 2'd2) ? 3'd1 : (mode_q == 2'd3) ? 3'd5 : 3'd3;
    pre_end   = pre_q == per_q;
    wrap      = pre_end && (step_q == last_step);
    fin       = wrap && (rep_q != 8'd0) && (pass_q == rep_q - 8'd1);
    pre_d     = pre_end ? '0 : pre_q + 1'b1;
    step_d    = pre_end ? ((step_q == last_step) ? 3'd0 : step_q + 3'd1) : step_q;
    pass_d    = wrap ? pass_q + 8'd1 : pass_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      per_q   <= '0;
      pre_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      step_q  <= '0;
      led_q   <= 4'b1111;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (cfg_valid) begin
            state_q <= RUN;
            mode_q  <= cfg_mode;
            per_q   <= (cfg_period == '0) ? '0 : cfg_period - 1'b1;
            rep_q   <= cfg_repeat;
            pre_q   <= '0;
            pass_q  <= '0;
            step_q  <= '0;
            led_q   <= pat(cfg_mode, 3'd0);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort || fin) begin
            state_q <= abort ? IDLE : DONE;
            done_q  <= !abort;
            led_q   <= 4'b1111;
            busy_q  <= 1'b0;
          end else begin
            pre_q  <= pre_d;
            step_q <= step_d;
            pass_q <= pass_d;
            led_q  <= pat(mode_q, step_d);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = state_q == IDLE;
  assign pio_led   = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: table-driven and randomized checks of led_pattern_ctrl against a cycle-index arithmetic model.
module tb_led_pattern_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = '0;
  logic [23:0] cfg_period = '0;
  logic [7:0]  cfg_repeat = '0;
  logic        abort = 1'b0;
  logic [3:0]  pio_led;
  logic        busy, done;
  int total = 0, bad = 0;
  logic [3:0] tbl [4][6];
  int lens [4];

  led_pattern_ctrl #(.DIV_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_repeat(cfg_repeat),
    .abort(abort), .pio_led(pio_led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m, p, r, ab, len;
    bit dn;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_led"}, 32'(pio_led), 32'hf);
    chk({nm, "_ready"}, 32'(cfg_ready), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
  endtask

  // Plays one command; the model derives every output from the run-cycle index k alone.
  task automatic run_cmd(input int m, input int p, input int r, input int ab,
                         input bit hold, input int hm, input int hp, input int hr,
                         output int run_len, output bit saw_done);
    int pe, len, fin;
    pe = (p == 0) ? 1 : p;
    len = lens[m];
    fin = r * len * pe;
    run_len = 0;
    saw_done = 0;
    cfg_valid = 1'b1;
    cfg_mode = 2'(m);
    cfg_period = 24'(p);
    cfg_repeat = 8'(r);
    abort = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4000; k++) begin
      if (r != 0 && k == fin) begin
        chk("done_led", 32'(pio_led), 32'hf);
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_ready", 32'(cfg_ready), 0);
        saw_done = done;
        abort = 1'($urandom);
        if (!hold) cfg_valid = 1'($urandom);
        @(posedge clk); #1;
        break;
      end
      chk("run_led", 32'(pio_led), 32'(tbl[m][(k / pe) % len]));
      chk("run_busy", 32'(busy), 1);
      chk("run_ready", 32'(cfg_ready), 0);
      chk("run_done", 32'(done), 0);
      run_len += int'(busy);
      if (hold) begin
        cfg_valid = 1'b1;
        cfg_mode = 2'(hm);
        cfg_period = 24'(hp);
        cfg_repeat = 8'(hr);
      end else begin
        cfg_valid = 1'($urandom);
        cfg_mode = 2'($urandom);
        cfg_period = 24'($urandom_range(0, 7));
        cfg_repeat = 8'($urandom);
      end
      abort = (k == ab);
      @(posedge clk); #1;
      if (k == ab) break;
      if (k == 3999) chk("run_bound", 0, 1);
    end
    idle_chk("ret_idle");
    abort = 1'($urandom);
    cfg_valid = hold;
  endtask

  initial begin
    vec_t vt[4];
    int rl, p, r, m, ab, fin, elen;
    bit dn, edn;
    tbl[0] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b1111};
    tbl[1] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1111};
    tbl[2] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    tbl[3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};
    lens = '{4, 4, 2, 6};
    vt[0] = '{m: 0, p: 3, r: 1, ab: -1, len: 12, dn: 1};
    vt[1] = '{m: 3, p: 1, r: 2, ab: -1, len: 12, dn: 1};
    vt[2] = '{m: 2, p: 0, r: 0, ab: 9,  len: 10, dn: 0};
    vt[3] = '{m: 1, p: 2, r: 1, ab: 7,  len: 8,  dn: 0};

    repeat (3) @(posedge clk);
    #1 idle_chk("reset_held");
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 idle_chk("reset_idle");

    foreach (vt[i]) begin
      run_cmd(vt[i].m, vt[i].p, vt[i].r, vt[i].ab, 0, 0, 0, 0, rl, dn);
      chk($sformatf("vec%0d_len", i), 32'(rl), 32'(vt[i].len));
      chk($sformatf("vec%0d_done", i), 32'(dn), 32'(vt[i].dn));
      cfg_valid = 1'b0;
      abort = 1'b0;
      @(posedge clk); #1;
    end

    // Command held valid through a run is taken only once the block is idle again.
    run_cmd(0, 1, 1, -1, 1, 1, 2, 1, rl, dn);
    chk("hold_first_len", 32'(rl), 4);
    run_cmd(1, 2, 1, -1, 0, 0, 0, 0, rl, dn);
    chk("hold_second_len", 32'(rl), 8);
    cfg_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a step.
    cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_period = 24'd4; cfg_repeat = 8'd0; abort = 1'b0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_led", 32'(pio_led), 32'b1011);
    #2 rst_n = 1'b0;
    #1 idle_chk("async_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(0, 1, 1, -1, 0, 0, 0, 0, rl, dn);
    chk("post_rst_len", 32'(rl), 4);
    cfg_valid = 1'b0;

    for (int n = 0; n < 30; n++) begin
      m = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 3));
      fin = r * lens[m] * ((p == 0) ? 1 : p);
      ab = (r == 0) ? int'($urandom_range(0, 29)) : int'($urandom_range(0, fin + 2));
      if (r != 0 && ab >= fin) ab = -1;
      elen = (ab >= 0) ? ab + 1 : fin;
      edn = (ab < 0);
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      run_cmd(m, p, r, ab, 0, 0, 0, 0, rl, dn);
      chk("rnd_len", 32'(rl), 32'(elen));
      chk("rnd_done", 32'(dn), 32'(edn));
      cfg_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
